// File: rtl/cpu_pkg.sv
// Shared CPU constants and types.
// Imported by the fetch unit and by anything that talks to it.
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int PC_STEP = 2;
    localparam logic [7:0] RESET_PC = 8'h00;
    localparam logic [7:0] NOP = 8'h00;

    typedef enum logic {
        RUN,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, drives instruction memory and
// hands fetched instructions to decode over a valid/ready pair.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int PC_STEP = cpu_pkg::PC_STEP,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc_address,
    input  logic [DATA_W-1:0] instr_in,
    output logic [DATA_W-1:0] ir_out,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt,
    input  logic              resume,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);

    fetch_state_t state;
    fetch_state_t state_nxt;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] jump_pc;
    logic              load;

    assign pc_address = pc;
    assign halted     = (state == HALTED);
    assign jump_pc    = {jump_target[ADDR_W-1:1], 1'b0};
    assign load       = !ir_valid || ir_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // halt wins over resume, so both together keep the unit halted
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (halt) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                if (resume && !halt) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            ir_out      <= DATA_W'(NOP);
            ir_pc       <= '0;
            ir_valid    <= 1'b0;
            fetch_count <= '0;
        end else if (state == RUN) begin
            if (halt) begin
                ir_valid <= 1'b0;
                if (jump_en) begin
                    pc <= jump_pc;
                end
            end else if (jump_en) begin
                pc       <= jump_pc;
                ir_valid <= 1'b0;
            end else if (load) begin
                ir_out   <= instr_in;
                ir_pc    <= pc;
                ir_valid <= 1'b1;
                pc       <= pc + ADDR_W'(PC_STEP);
                if (fetch_count != '1) begin
                    fetch_count <= fetch_count + CNT_W'(1);
                end
            end
        end else begin
            ir_valid <= 1'b0;
            if (jump_en) begin
                pc <= jump_pc;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scenario bench for the fetch unit: combinational memory model,
// transfer scoreboard fed by each scenario and drained by a monitor.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  pc_address;
    logic [7:0]  instr_in;
    logic [7:0]  ir_out;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        jump_en;
    logic [7:0]  jump_target;
    logic        halt;
    logic        resume;
    logic        halted;
    logic [15:0] fetch_count;

    logic [7:0]  mem [256];
    logic [15:0] sb [$];
    int          checks;
    int          errors;

    instruction_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pc_address  (pc_address),
        .instr_in    (instr_in),
        .ir_out      (ir_out),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .halt        (halt),
        .resume      (resume),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instr_in = mem[pc_address];

    // Every decode transfer must match the oldest expected entry
    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst && ir_valid && ir_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected: got pc=%h instr=%h, none expected",
                         ir_pc, ir_out);
            end else begin
                e = sb.pop_front();
                if ({ir_pc, ir_out} !== e) begin
                    errors++;
                    $display("FAIL xfer: got pc=%h instr=%h, want pc=%h instr=%h",
                             ir_pc, ir_out, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_xfer(input logic [7:0] a);
        sb.push_back({a, mem[a]});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ir_ready = 1'b0;
        jump_en = 1'b0;
        jump_target = 8'h00;
        halt = 1'b0;
        resume = 1'b0;
        sb.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic end_scenario(input string name);
        @(negedge clk);
        #1;
        ir_ready = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d transfers missing, want 0",
                     name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ir_ready = 1'b1;
        jump_en = 1'b1;
        jump_target = 8'h40;
        halt = 1'b0;
        resume = 1'b0;
        tick();
        tick();
        checks++;
        if ({pc_address, ir_out, ir_pc, ir_valid, halted, fetch_count}
            !== {8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL reset: got pc=%h ir=%h irpc=%h v=%b h=%b cnt=%0d, want all 0",
                     pc_address, ir_out, ir_pc, ir_valid, halted, fetch_count);
        end
        jump_en = 1'b0;
    endtask

    task automatic test_sequential();
        logic [7:0] exp_ir [4];
        exp_ir = '{8'h00, 8'hD3, 8'h50, 8'hD1};
        do_reset();
        ir_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_xfer(8'(2 * i));
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ir_out !== exp_ir[i] || ir_pc !== 8'(2 * i) || ir_valid !== 1'b1) begin
                errors++;
                $display("FAIL seq_%0d: got ir=%h pc=%h v=%b, want ir=%h pc=%h v=1",
                         i, ir_out, ir_pc, ir_valid, exp_ir[i], 8'(2 * i));
            end
        end
        checks++;
        if (fetch_count !== 16'd4 || pc_address !== 8'h08) begin
            errors++;
            $display("FAIL seq_count: got cnt=%0d pc=%h, want cnt=4 pc=08",
                     fetch_count, pc_address);
        end
        end_scenario("seq");
    endtask

    task automatic test_stall();
        do_reset();
        ir_ready = 1'b1;
        expect_xfer(8'h00);
        tick();
        tick();
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ir_out !== 8'hD3 || ir_pc !== 8'h02 || pc_address !== 8'h04
                || ir_valid !== 1'b1 || fetch_count !== 16'd2) begin
                errors++;
                $display("FAIL stall_%0d: got ir=%h irpc=%h pc=%h v=%b cnt=%0d, want D3 02 04 1 2",
                         i, ir_out, ir_pc, pc_address, ir_valid, fetch_count);
            end
        end
        expect_xfer(8'h02);
        expect_xfer(8'h04);
        ir_ready = 1'b1;
        tick();
        checks++;
        if (ir_out !== 8'h50 || ir_pc !== 8'h04 || fetch_count !== 16'd3) begin
            errors++;
            $display("FAIL stall_release: got ir=%h irpc=%h cnt=%0d, want 50 04 3",
                     ir_out, ir_pc, fetch_count);
        end
        end_scenario("stall");
    endtask

    task automatic test_jump();
        do_reset();
        ir_ready = 1'b1;
        for (int i = 0; i < 3; i++) expect_xfer(8'(2 * i));
        tick();
        tick();
        tick();
        jump_en = 1'b1;
        jump_target = 8'h09;
        tick();
        jump_en = 1'b0;
        checks++;
        if (ir_valid !== 1'b0 || pc_address !== 8'h08) begin
            errors++;
            $display("FAIL jump_flush: got v=%b pc=%h, want v=0 pc=08",
                     ir_valid, pc_address);
        end
        expect_xfer(8'h08);
        tick();
        checks++;
        if (ir_valid !== 1'b1 || ir_pc !== 8'h08 || ir_out !== mem[8'h08]
            || fetch_count !== 16'd4) begin
            errors++;
            $display("FAIL jump_target: got v=%b irpc=%h ir=%h cnt=%0d, want 1 08 %h 4",
                     ir_valid, ir_pc, ir_out, fetch_count, mem[8'h08]);
        end
        end_scenario("jump");
    endtask

    task automatic test_wrap();
        logic [7:0] a;
        do_reset();
        ir_ready = 1'b1;
        jump_en = 1'b1;
        jump_target = 8'hFC;
        tick();
        jump_en = 1'b0;
        expect_xfer(8'hFC);
        expect_xfer(8'hFE);
        expect_xfer(8'h00);
        a = 8'hFC;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ir_pc !== a || ir_out !== mem[a] || ir_valid !== 1'b1) begin
                errors++;
                $display("FAIL wrap_%0d: got irpc=%h ir=%h v=%b, want %h %h 1",
                         i, ir_pc, ir_out, ir_valid, a, mem[a]);
            end
            a = a + 8'd2;
        end
        checks++;
        if (pc_address !== 8'h02) begin
            errors++;
            $display("FAIL wrap_pc: got %h, want 02", pc_address);
        end
        end_scenario("wrap");
    endtask

    task automatic test_halt_resume();
        do_reset();
        ir_ready = 1'b1;
        expect_xfer(8'h00);
        expect_xfer(8'h02);
        tick();
        tick();
        halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            halt = 1'b0;
            checks++;
            if (halted !== 1'b1 || ir_valid !== 1'b0 || pc_address !== 8'h04) begin
                errors++;
                $display("FAIL halt_%0d: got h=%b v=%b pc=%h, want 1 0 04",
                         i, halted, ir_valid, pc_address);
            end
        end
        halt = 1'b1;
        resume = 1'b1;
        tick();
        halt = 1'b0;
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_and_resume: got h=%b, want 1", halted);
        end
        tick();
        resume = 1'b0;
        checks++;
        if (halted !== 1'b0 || ir_valid !== 1'b0 || pc_address !== 8'h04) begin
            errors++;
            $display("FAIL resume: got h=%b v=%b pc=%h, want 0 0 04",
                     halted, ir_valid, pc_address);
        end
        expect_xfer(8'h04);
        tick();
        checks++;
        if (ir_valid !== 1'b1 || ir_pc !== 8'h04 || ir_out !== 8'h50) begin
            errors++;
            $display("FAIL resume_fetch: got v=%b irpc=%h ir=%h, want 1 04 50",
                     ir_valid, ir_pc, ir_out);
        end
        end_scenario("halt");
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        ir_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_xfer(8'(2 * i));
        for (int i = 0; i < 5; i++) tick();
        ir_ready = 1'b0;
        tick();
        checks++;
        if (pc_address !== 8'h0A || ir_valid !== 1'b1 || ir_pc !== 8'h08) begin
            errors++;
            $display("FAIL pre_reset_stall: got pc=%h v=%b irpc=%h, want 0A 1 08",
                     pc_address, ir_valid, ir_pc);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pre_reset_drain: %0d transfers missing, want 0", sb.size());
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (pc_address !== 8'h00 || ir_valid !== 1'b0 || fetch_count !== 16'd0
            || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stall: got pc=%h v=%b cnt=%0d h=%b, want 00 0 0 0",
                     pc_address, ir_valid, fetch_count, halted);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[8'h00] = 8'h00;
        mem[8'h02] = 8'hD3;
        mem[8'h04] = 8'h50;
        mem[8'h06] = 8'hD1;
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_wrap();
        test_halt_resume();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Requester side of the instruction-memory interface.
- Owns the program counter and drives pc_address to the combinational instruction memory.
- Captures the returned instruction into an instruction register and hands it to decode over a valid/ready handshake.
- Handles jumps (flush plus redirect), halt/resume and PC wrap-around, and keeps a fetch counter for debug.

Parameters:
- ADDR_W, 8, PC and address width.
- DATA_W, 8, instruction width.
- PC_STEP, 2, PC increment per sequential fetch; instructions sit at even addresses.
- RESET_PC, 8'h00, PC value after reset.
- CNT_W, 16, fetch counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_address  out  ADDR_W  address to instruction memory; equals the PC register (combinational from register).
- instr_in  in  DATA_W  instruction returned by memory in the same cycle.
- ir_out  out  DATA_W  registered instruction presented to decode.
- ir_pc  out  ADDR_W  address from which ir_out was fetched.
- ir_valid  out  1  ir_out holds a valid instruction.
- ir_ready  in  1  decode accepts ir_out this cycle.
- jump_en  in  1  redirect request from execute.
- jump_target  in  ADDR_W  redirect address; bit 0 forced to 0.
- halt  in  1  request to stop fetching.
- resume  in  1  leave the HALTED state.
- halted  out  1  high while in HALTED.
- fetch_count  out  CNT_W  number of instructions loaded into the IR; saturating.

Behaviour:
- Reset (rst=1 at a clock edge):
  - PC=RESET_PC, ir_out=0, ir_pc=0, ir_valid=0, halted=0, fetch_count=0, state=RUN.
  - Reset overrides every other input, including mid-stall and mid-jump.
- States: RUN, HALTED.
- Load condition in RUN: load = !ir_valid || ir_ready.
- RUN, priority order (highest first):
  1. halt=1:
     - go to HALTED, ir_valid<=0, PC unchanged.
     - If a jump is also requested, PC<=jump_target & ~1 (the jump is still honoured).
  2. jump_en=1:
     - PC<=jump_target & ~1, ir_valid<=0 (flush), no fetch this cycle.
     - The instruction fetched at the redirect target appears in the IR one cycle later.
  3. load=1:
     - ir_out<=instr_in, ir_pc<=PC, ir_valid<=1, PC<=PC+PC_STEP.
     - fetch_count increments by 1, saturating at all ones.
  4. Otherwise (stall: ir_valid=1, ir_ready=0): IR, PC and counter hold.
- HALTED:
  - halted=1, ir_valid=0, PC holds.
  - jump_en still updates PC.
  - resume=1 -> RUN next cycle; the first fetch happens in the following cycle.
  - halt and resume together: stay HALTED.
- Latency: one instruction per cycle while ir_ready=1. First valid IR appears 1 cycle after rst deasserts.
- Handshake rules:
  - While ir_valid=1 and ir_ready=0, ir_out and ir_pc are stable.
  - Transfer to decode occurs when ir_valid && ir_ready. A new instruction may be loaded in the same edge.
- Wrap-around: PC arithmetic is modulo 2^ADDR_W; 8'hFE + 2 -> 8'h00 with no flag.
- Odd jump targets are silently aligned (8'h07 -> 8'h06).
- pc_address is glitch-free: register output only.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W, DATA_W, PC_STEP, RESET_PC constants.
  - Fetch state enum {RUN, HALTED}.
  - NOP encoding 8'h00.
- Single flat module. No sub-module needed; the saturating counter is inline.

Test Plan:
- Sequential fetch, memory model 0x00->8'h00, 0x02->8'hD3, 0x04->8'h50, 0x06->8'hD1, ir_ready=1 after reset -> ir_out sequence 00, D3, 50, D1 on consecutive cycles; ir_pc 00, 02, 04, 06; fetch_count=4.
- Stall: ir_ready=0 for 3 cycles while ir_out=8'hD3 -> ir_out, ir_pc=02 and PC=04 are held; fetch_count is unchanged; loading resumes the cycle ir_ready returns to 1.
- Jump: jump_en=1, jump_target=8'h09 while PC=06 -> ir_valid=0 next cycle, pc_address=08; following cycle ir_pc=08, ir_out=mem[08].
- Wrap-around: jump to 8'hFC, run 3 fetches -> ir_pc FC, FE, 00; pc_address=02.
- Halt/resume: halt=1 at PC=04 -> halted=1, ir_valid=0, pc_address stays 04 for 5 cycles; resume=1 -> halted=0 next cycle, then ir_pc=04 valid.
- Reset mid-stall: rst=1 while ir_valid=1, ir_ready=0, PC=0A -> next cycle PC=00, ir_valid=0, fetch_count=0, halted=0.
